// File: rtl/uart_div_pkg.sv
// Shared types and constants for the UART divider controller and its restoring divider.
package uart_div_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DEFAULT_DATA_BYTES = 2;

  typedef enum logic [1:0] {
    S_RX   = 2'd0,
    S_DIV  = 2'd1,
    S_LOAD = 2'd2,
    S_TX   = 2'd3
  } state_e;

  // Bit offset of byte slot idx inside a little-endian word.
  function automatic int unsigned byte_lsb(input int unsigned idx);
    return idx * BYTE_W;
  endfunction

endpackage

// File: rtl/uart_div_ctrl_div_restoring.sv
// Iterative restoring divider, one quotient bit per clock; divisor 0 finishes on the next cycle.
module div_restoring #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         dbz
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     quo_q, quo_d, rem_q, rem_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [W:0]       rem_sh;

  // quo_q starts as the dividend and has quotient bits shifted in from the bottom.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    rem_sh = {rem_q, quo_q[W-1]};
    if (start) begin
      b_d = b;
      if (b == '0) begin
        quo_d  = '1;
        rem_d  = a;
        cnt_d  = '0;
        dbz_d  = 1'b1;
        done_d = 1'b1;
      end else begin
        quo_d = a;
        rem_d = '0;
        cnt_d = CNT_W'(W);
        dbz_d = 1'b0;
      end
    end else if (cnt_q != '0) begin
      if (rem_sh >= {1'b0, b_q}) begin
        rem_d = W'(rem_sh - {1'b0, b_q});
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: rtl/uart_div_ctrl.sv
// UART byte-stream divider controller: rx frame -> restoring divide -> tx quotient/remainder.
// Optional inter-byte receive timeout enabled with macro UART_DIV_RX_TIMEOUT_EN.
module uart_div_ctrl
  import uart_div_pkg::*;
#(
  parameter int unsigned DATA_BYTES = DEFAULT_DATA_BYTES,
  parameter int unsigned LED_W      = 24,
  parameter int unsigned TO_CYCLES  = 104160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic [LED_W-1:0] led_q,
  output logic             busy,
  output logic             div_err
);

  localparam int unsigned W     = BYTE_W * DATA_BYTES;
  localparam int unsigned NB    = 2 * DATA_BYTES;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  if (TO_CYCLES == 0 || DATA_BYTES == 0) begin : g_param_chk
    $error("uart_div_ctrl: TO_CYCLES and DATA_BYTES must be non-zero");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2*W-1:0]   op_q, op_d;
  logic             tx_valid_q, tx_valid_d, busy_q, busy_d, div_err_q, div_err_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [LED_W-1:0] led_d;
  logic             start_c, div_done, div_dbz;
  logic [W-1:0]     div_quo, div_rem;
  logic [2*W-1:0]   res;

`ifdef UART_DIV_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign res = {div_rem, div_quo};

  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    op_d       = op_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    div_err_d  = div_err_q;
    led_d      = led_q;
    start_c    = 1'b0;
    unique case (state_q)
      S_RX: begin
        if (rx_valid) begin
          op_d[byte_lsb(32'(rx_cnt_q)) +: BYTE_W] = rx_data;
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
          busy_d   = 1'b1;
          if (rx_cnt_q == CNT_W'(NB - 1)) begin
            start_c = 1'b1;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        if (div_done) state_d = S_LOAD;
      end
      S_LOAD: begin
        led_d      = LED_W'(div_quo);
        div_err_d  = div_dbz;
        tx_valid_d = 1'b1;
        tx_data_d  = res[BYTE_W-1:0];
        tx_cnt_d   = '0;
        state_d    = S_TX;
      end
      S_TX: begin
        if (tx_valid_q && tx_ready) begin
          if (tx_cnt_q == CNT_W'(NB - 1)) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            rx_cnt_d   = '0;
            state_d    = S_RX;
          end else begin
            tx_cnt_d  = tx_cnt_q + CNT_W'(1);
            tx_data_d = res[byte_lsb(32'(tx_cnt_d)) +: BYTE_W];
          end
        end
      end
      default: state_d = S_RX;
    endcase

`ifdef UART_DIV_RX_TIMEOUT_EN
    // A stalled partial frame is discarded so the next strobe starts a fresh frame.
    to_cnt_d = '0;
    if (state_q == S_RX && rx_cnt_q != '0 && !rx_valid) begin
      if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
        rx_cnt_d = '0;
        busy_d   = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RX;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      op_q       <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      div_err_q  <= 1'b0;
      led_q      <= '0;
`ifdef UART_DIV_RX_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      op_q       <= op_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      div_err_q  <= div_err_d;
      led_q      <= led_d;
`ifdef UART_DIV_RX_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Operands come from op_d so the divider starts on the same edge that captures the last byte.
  div_restoring #(.W(W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .a     (op_d[W-1:0]),
    .b     (op_d[2*W-1:W]),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem),
    .dbz   (div_dbz)
  );

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign div_err  = div_err_q;

endmodule

// File: tb/tb_uart_div_ctrl.sv
// Directed self-checking bench for uart_div_ctrl (2-byte and 4-byte operand instances).
module tb_uart_div_ctrl;

  logic        clk, rst;
  logic        rx_valid1, tx_ready1, tx_valid1, busy1, derr1;
  logic [7:0]  rx_data1, tx_data1;
  logic [23:0] led1;
  logic        rx_valid2, tx_ready2, tx_valid2, busy2, derr2;
  logic [7:0]  rx_data2, tx_data2;
  logic [23:0] led2;
  int          checks, failures;

  uart_div_ctrl #(.DATA_BYTES(2), .LED_W(24), .TO_CYCLES(200)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid1), .rx_data(rx_data1), .tx_ready(tx_ready1),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .led_q(led1), .busy(busy1), .div_err(derr1)
  );

  uart_div_ctrl #(.DATA_BYTES(4), .LED_W(24), .TO_CYCLES(200)) dut2 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid2), .rx_data(rx_data2), .tx_ready(tx_ready2),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .led_q(led2), .busy(busy2), .div_err(derr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tv(input int sel);
    return (sel == 2) ? tx_valid2 : tx_valid1;
  endfunction
  function automatic logic [7:0] td(input int sel);
    return (sel == 2) ? tx_data2 : tx_data1;
  endfunction
  function automatic logic bz(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  task automatic set_ready(input int sel, input logic r);
    if (sel == 2) tx_ready2 = r;
    else          tx_ready1 = r;
  endtask

  task automatic send(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 2) begin rx_valid2 = 1'b1; rx_data2 = b; end
    else          begin rx_valid1 = 1'b1; rx_data1 = b; end
    @(negedge clk);
    rx_valid1 = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  // Waits for a byte, optionally stalls it, then accepts it on the next edge.
  task automatic get(input int sel, input int stall, output logic [7:0] b);
    int n;
    logic [7:0] d;
    logic stable;
    n = 0;
    while (!tv(sel) && n < 300) begin @(negedge clk); n++; end
    chk("tx_valid_wait", 64'(tv(sel)), 64'd1);
    d = td(sel);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      set_ready(sel, 1'b0);
      @(negedge clk);
      if (!(tv(sel) === 1'b1 && td(sel) === d)) stable = 1'b0;
    end
    if (stall > 0) chk("tx_hold_stable", 64'(stable), 64'd1);
    chk("busy_before_accept", 64'(bz(sel)), 64'd1);
    b = td(sel);
    set_ready(sel, 1'b1);
    @(negedge clk);
  endtask

  task automatic frame(input int sel, input int nb, input logic [63:0] din,
                       input logic [63:0] dexp, input int exp_lat, input int stall,
                       input string tag);
    int lat;
    logic [7:0] b;
    for (int i = 0; i < nb; i++) send(sel, din[8*i +: 8]);
    lat = 0;
    while (!tv(sel) && lat < 300) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i < nb; i++) begin
      get(sel, stall, b);
      chk($sformatf("%s_byte%0d", tag, i), 64'(b), 64'(dexp[8*i +: 8]));
    end
    chk({tag, "_busy_done"}, 64'(bz(sel)), 64'd0);
    repeat (5) @(negedge clk);
    chk({tag, "_no_extra_tx"}, 64'(tv(sel)), 64'd0);
  endtask

  initial begin
    logic [7:0] b;
    checks = 0; failures = 0;
    rst = 1'b0;
    rx_valid1 = 1'b0; rx_data1 = 8'h00; tx_ready1 = 1'b1;
    rx_valid2 = 1'b0; rx_data2 = 8'h00; tx_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 64'(tx_valid1), 64'd0);
    chk("rst_tx_data",  64'(tx_data1),  64'd0);
    chk("rst_led",      64'(led1),      64'd0);
    chk("rst_busy",     64'(busy1),     64'd0);
    chk("rst_div_err",  64'(derr1),     64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1000 / 7 = 142 r 6
    frame(1, 4, {32'h0, 16'h0007, 16'h03E8}, {32'h0, 16'h0006, 16'h008E}, 18, 0, "div1000_7");
    chk("led_1000_7",  64'(led1),  64'h00008E);
    chk("derr_1000_7", 64'(derr1), 64'd0);

    // divide by zero: quotient all ones, remainder = dividend
    frame(1, 4, {32'h0, 16'h0000, 16'h1234}, {32'h0, 16'h1234, 16'hFFFF}, 2, 0, "dbz");
    chk("derr_dbz", 64'(derr1), 64'd1);
    chk("led_dbz",  64'(led1),  64'h00FFFF);

    // 50000 / 300 = 166 r 200 with 50-cycle stall on every byte
    frame(1, 4, {32'h0, 16'h012C, 16'hC350}, {32'h0, 16'h00C8, 16'h00A6}, 18, 50, "stall");
    chk("derr_stall_clear", 64'(derr1), 64'd0);
    chk("led_stall",        64'(led1),  64'h0000A6);

    // 4-byte operands: 0xFFFFFFFF / 0x00010000 = 0xFFFF r 0xFFFF
    frame(2, 8, {32'h0001_0000, 32'hFFFF_FFFF}, {32'h0000_FFFF, 32'h0000_FFFF}, 34, 0, "w32");
    chk("led_w32",  64'(led2),  64'h00FFFF);
    chk("derr_w32", 64'(derr2), 64'd0);

    // reset mid-frame, then 100 / 10
    send(1, 8'hE8); send(1, 8'h03); send(1, 8'h07);
    chk("busy_partial", 64'(busy1), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy",     64'(busy1),     64'd0);
    chk("midrst_tx_valid", 64'(tx_valid1), 64'd0);
    chk("midrst_led",      64'(led1),      64'd0);
    rst = 1'b1;
    @(negedge clk);
    frame(1, 4, {32'h0, 16'h000A, 16'h0064}, {32'h0, 16'h0000, 16'h000A}, 18, 0, "after_rst");

    // lone byte followed by a long gap, then frame 9 / 2
    send(1, 8'h05);
    repeat (205) @(negedge clk);
`ifdef UART_DIV_RX_TIMEOUT_EN
    chk("timeout_busy", 64'(busy1), 64'd0);
    frame(1, 4, {32'h0, 16'h0002, 16'h0009}, {32'h0, 16'h0001, 16'h0004}, 18, 0, "to_9_2");
`else
    chk("no_timeout_busy", 64'(busy1), 64'd1);
    // frame becomes 05 09 00 02 = 0x0905 / 0x0200 = 4 r 0x105; trailing 00 lands mid-divide
    send(1, 8'h09); send(1, 8'h00); send(1, 8'h02); send(1, 8'h00);
    get(1, 0, b); chk("keep_byte0", 64'(b), 64'h04);
    get(1, 0, b); chk("keep_byte1", 64'(b), 64'h00);
    get(1, 0, b); chk("keep_byte2", 64'(b), 64'h05);
    get(1, 0, b); chk("keep_byte3", 64'(b), 64'h01);
    repeat (5) @(negedge clk);
    chk("dropped_byte_idle", 64'(busy1), 64'd0);
    chk("dropped_byte_no_tx", 64'(tx_valid1), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
